// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : MIPS-style HI/LO multiply/divide unit with fixed-latency busy.
// Revision : 1.0
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]        r_hi, w_hi_nxt;
    logic [31:0]        r_lo, w_lo_nxt;
    logic [31:0]        r_res_hi, w_res_hi_nxt;
    logic [31:0]        r_res_lo, w_res_lo_nxt;
    logic               r_res_ok, w_res_ok_nxt;

    logic        w_accept;
    logic        w_mul_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;

    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_div;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_accept = (r_state == ST_IDLE) && start &&
                      (md_op >= c_OP_MULT) && (md_op <= c_OP_MTLO);

    // Low 64 bits of the extended product are correct for both signednesses.
    assign w_mul_signed = (md_op == c_OP_MULT);
    assign w_a_ext      = {{32{w_mul_signed & A[31]}}, A};
    assign w_b_ext      = {{32{w_mul_signed & B[31]}}, B};
    assign w_prod       = w_a_ext * w_b_ext;

    // Sign-magnitude division: truncates toward zero and makes
    // 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
    assign w_div_signed = (md_op == c_OP_DIV);
    assign w_a_neg      = w_div_signed & A[31];
    assign w_b_neg      = w_div_signed & B[31];
    assign w_b_zero     = (B == 32'd0);
    assign w_a_mag      = w_a_neg ? (32'd0 - A) : A;
    assign w_b_mag      = w_b_neg ? (32'd0 - B) : B;
    assign w_b_div      = w_b_zero ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_div;
    assign w_r_mag      = w_a_mag % w_b_div;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_res_hi_nxt = r_res_hi;
        w_res_lo_nxt = r_res_lo;
        w_res_ok_nxt = r_res_ok;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (md_op)
                        c_OP_MULT, c_OP_MULTU: begin
                            w_state_nxt  = ST_MUL;
                            w_cnt_nxt    = c_MUL_LOAD;
                            w_res_hi_nxt = w_prod[63:32];
                            w_res_lo_nxt = w_prod[31:0];
                            w_res_ok_nxt = 1'b1;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            w_state_nxt  = ST_DIV;
                            w_cnt_nxt    = c_DIV_LOAD;
                            w_res_hi_nxt = w_rem;
                            w_res_lo_nxt = w_quot;
                            w_res_ok_nxt = ~w_b_zero;
                        end
                        c_OP_MTHI: w_hi_nxt = A;
                        c_OP_MTLO: w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = c_CNT_ZERO;
                    w_res_ok_nxt = 1'b0;
                    if (r_res_ok) begin
                        w_hi_nxt = r_res_hi;
                        w_lo_nxt = r_res_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= c_CNT_ZERO;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
            r_res_ok <= w_res_ok_nxt;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed, table-driven self-checking bench for mult_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

    localparam logic [2:0] c_NONE  = 3'd0;
    localparam logic [2:0] c_MULT  = 3'd1;
    localparam logic [2:0] c_MULTU = 3'd2;
    localparam logic [2:0] c_DIV   = 3'd3;
    localparam logic [2:0] c_DIVU  = 3'd4;
    localparam logic [2:0] c_MTHI  = 3'd5;
    localparam logic [2:0] c_MTLO  = 3'd6;
    localparam logic [2:0] c_RSVD  = 3'd7;
    localparam int         c_NVEC  = 15;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] mdl_hi  = 32'd0;
    logic [31:0] mdl_lo  = 32'd0;
    vec_t        vecs [c_NVEC];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, input int cyc);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
        return v;
    endfunction

    // Issue at a negedge, scramble operands after acceptance, count busy cycles.
    task automatic run_vec(input vec_t v);
        int cyc;
        start = 1'b1; md_op = v.op; A = v.a; B = v.b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = c_NONE; A = $urandom; B = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 60) begin
            check({v.name, " hi_hold"}, {32'd0, HI}, {32'd0, mdl_hi});
            check({v.name, " lo_hold"}, {32'd0, LO}, {32'd0, mdl_lo});
            cyc++;
            @(negedge clk);
        end
        check({v.name, " busy_cycles"}, 64'(cyc), 64'(v.cyc));
        check({v.name, " HI"}, {32'd0, HI}, {32'd0, v.hi});
        check({v.name, " LO"}, {32'd0, LO}, {32'd0, v.lo});
        mdl_hi = v.hi;
        mdl_lo = v.lo;
    endtask

    initial begin
        vecs[0]  = mk("mult_neg1x2",   c_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        vecs[1]  = mk("multu_maxx2",   c_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5);
        vecs[2]  = mk("div_m7_2",      c_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        vecs[3]  = mk("divu_7_2",      c_DIVU,  32'h7,        32'h2, 32'h1,        32'h3,        10);
        vecs[4]  = mk("mthi_1111",     c_MTHI,  32'h11111111, 32'h0, 32'h11111111, 32'h3,        0);
        vecs[5]  = mk("mtlo_2222",     c_MTLO,  32'h22222222, 32'h0, 32'h11111111, 32'h22222222, 0);
        vecs[6]  = mk("divu_by_zero",  c_DIVU,  32'h5,        32'h0, 32'h11111111, 32'h22222222, 10);
        vecs[7]  = mk("div_overflow",  c_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
        vecs[8]  = mk("mthi_1234",     c_MTHI,  32'h12345678, 32'h0, 32'h12345678, 32'h80000000, 0);
        vecs[9]  = mk("mult_7_m3",     c_MULT,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        vecs[10] = mk("div_7_m2",      c_DIV,   32'h7,        32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10);
        vecs[11] = mk("multu_2p16sq",  c_MULTU, 32'h10000,    32'h10000, 32'h1, 32'h0, 5);
        vecs[12] = mk("op_none",       c_NONE,  32'hAAAA5555, 32'h3, 32'h1, 32'h0, 0);
        vecs[13] = mk("op_reserved",   c_RSVD,  32'hAAAA5555, 32'h3, 32'h1, 32'h0, 0);
        vecs[14] = mk("div_m8_m3",     c_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h2, 10);

        reset = 1'b0; start = 1'b0; md_op = c_NONE; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset HI", {32'd0, HI}, 64'd0);
        check("reset LO", {32'd0, LO}, 64'd0);

        // Reset must win over a simultaneous start.
        start = 1'b1; md_op = c_MULT; A = 32'd3; B = 32'd5;
        @(negedge clk);
        check("rst_prio busy", {63'd0, busy}, 64'd0);
        check("rst_prio LO", {32'd0, LO}, 64'd0);
        reset = 1'b1; start = 1'b0; md_op = c_NONE;
        @(negedge clk);
        check("rst_prio busy after release", {63'd0, busy}, 64'd0);

        for (int i = 0; i < c_NVEC; i++) run_vec(vecs[i]);

        // Mult with mtlo/div pulses inside the busy window and on completion.
        start = 1'b1; md_op = c_MULT; A = 32'd3; B = 32'd5;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("pulse busy k%0d", k), {63'd0, busy}, 64'd1);
            check($sformatf("pulse LO hold k%0d", k), {32'd0, LO}, {32'd0, mdl_lo});
            start = (k == 2) || (k == 3) || (k == 5);
            md_op = (k == 2) ? c_MTLO : c_DIV;
            A     = 32'hDEADBEEF;
            B     = 32'd7;
        end
        @(negedge clk);
        start = 1'b0; md_op = c_NONE;
        check("pulse busy drop", {63'd0, busy}, 64'd0);
        check("pulse HI", {32'd0, HI}, 64'd0);
        check("pulse LO", {32'd0, LO}, 64'd15);
        @(negedge clk);
        check("pulse no late accept", {63'd0, busy}, 64'd0);
        check("pulse LO stable", {32'd0, LO}, 64'd15);
        mdl_hi = 32'd0; mdl_lo = 32'd15;

        // Reset asserted on the third busy cycle of a divide.
        run_vec(mk("mthi_pre", c_MTHI, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'd15, 0));
        start = 1'b1; md_op = c_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0; md_op = c_NONE;
            check($sformatf("abort busy k%0d", k), {63'd0, busy}, 64'd1);
            if (k == 3) reset = 1'b0;
        end
        @(negedge clk);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort HI", {32'd0, HI}, 64'd0);
        check("abort LO", {32'd0, LO}, 64'd0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort no late busy", {63'd0, busy}, 64'd0);
        check("abort no late HI", {32'd0, HI}, 64'd0);
        check("abort no late LO", {32'd0, LO}, 64'd0);
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        run_vec(mk("divu_after_abort", c_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL take parameter MULT_CYCLES, default 5, which sets the busy duration of mult/multu.
REQ-002 The block SHALL take parameter DIV_CYCLES, default 10, which sets the busy duration of div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset; 0 at a rising edge of clk resets the block.
REQ-005 The block SHALL have port start, input, 1 bit: E-stage issues a mult/div-class instruction this cycle.
REQ-006 The block SHALL have port md_op, input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 The block SHALL have port A, input, 32 bits: forwarded rs operand.
REQ-008 The block SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in flight; feeds the hazard stall logic.
REQ-010 The block SHALL have port HI, output, 32 bits: the architectural HI register.
REQ-011 The block SHALL have port LO, output, 32 bits: the architectural LO register.

Function
REQ-012 States SHALL be IDLE, MUL and DIV; busy SHALL be 1 exactly when the state is not IDLE.
REQ-013 Accept rule: a command SHALL be accepted only on an edge where reset=1, busy=0, start=1 and md_op is 1-6; all other start pulses SHALL be ignored with no state change.
REQ-014 On accepting mult or multu, the block SHALL capture the 64-bit product (signed for mult, unsigned for multu), enter MUL and load cycle counter = MULT_CYCLES.
REQ-015 On accepting div or divu, the block SHALL capture quotient and remainder (signed for div, unsigned for divu), enter DIV and load counter = DIV_CYCLES.
REQ-016 In MUL or DIV, each edge SHALL decrement the counter.
REQ-017 On the edge where the counter equals 1, the block SHALL write HI/LO, clear the counter, return to IDLE and drop busy on that same edge.
REQ-018 busy SHALL therefore be high for exactly MULT_CYCLES or DIV_CYCLES cycles following the accepting edge.
REQ-019 Multiply results: HI SHALL receive product[63:32] and LO product[31:0].
REQ-020 Divide results: LO SHALL receive the quotient and HI the remainder.
REQ-021 Signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 Divide by zero (B=0) SHALL still run DIV_CYCLES with busy high, but HI and LO SHALL remain unchanged at completion.
REQ-024 mthi SHALL write A into HI on the accepting edge, and mtlo SHALL write A into LO on the accepting edge; neither SHALL raise busy or alter the other register.
REQ-025 Operands SHALL be sampled only on the accepting edge; later changes to A/B during busy SHALL have no effect on the result.
REQ-026 HI/LO SHALL hold their value between writes; while busy=1, HI/LO SHALL show the old values until the completion edge.
REQ-027 A start on the completion edge SHALL be ignored; the block accepts a new command from the first cycle with busy=0.
REQ-028 The outputs SHALL be registered only, with no combinational path from start/md_op to busy.

Reset
REQ-029 On an edge with reset=0, the block SHALL set HI=0, LO=0, busy=0, counter=0 and state=IDLE, and discard any captured result.
REQ-030 reset=0 mid-operation SHALL abort the operation, and its result SHALL never be written.
REQ-031 reset SHALL take priority over start on the same edge.

Verification
REQ-032 mult A=0xFFFFFFFF, B=0x00000002 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 div A=0xFFFFFFF9 (-7), B=0x00000002 -> busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-034 HI=0x11111111, LO=0x22222222, then divu A=5, B=0 -> busy high 10 cycles, then HI=0x11111111, LO=0x22222222 unchanged.
REQ-035 mthi A=0x12345678 while idle -> HI=0x12345678 after one edge, busy stays 0, LO unchanged; mtlo issued during a mult's busy window -> ignored, and LO equals the mult result at completion.
REQ-036 Start div, drive reset=0 on the 3rd busy cycle -> next edge busy=0, HI=0, LO=0; no later write occurs.
REQ-037 Start mult, pulse start with div on the 2nd busy cycle and on the completion edge -> both ignored, busy falls after exactly 5 cycles, HI/LO hold the mult result.
